// File: rtl/fft_bfy_sched.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT with one butterfly core.
// Issues one butterfly per cycle per stage, drains the core between stages, and delays write-back addresses.
module fft_bfy_sched #(
   parameter int FFT_LOG2 = 6,
   parameter int BFY_LAT  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [2:0]          stage_o,
   output logic                rd_vld_o,
   output logic [FFT_LOG2-1:0] rd_addr1_o,
   output logic [FFT_LOG2-1:0] rd_addr2_o,
   output logic [FFT_LOG2-2:0] tw_idx_o,
   output logic                wr_vld_o,
   output logic [FFT_LOG2-1:0] wr_addr1_o,
   output logic [FFT_LOG2-1:0] wr_addr2_o
);

   localparam int              AW     = FFT_LOG2;
   localparam int              BW     = FFT_LOG2 - 1;
   localparam logic [BW-1:0]   B_LAST = {BW{1'b1}};
   localparam logic [2:0]      S_LAST = 3'(FFT_LOG2 - 1);
   localparam logic [2:0]      D_LAST = 3'(BFY_LAT - 1);
   localparam logic [2:0]      TW_SH  = 3'(BW);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        r_state;
   logic [BW-1:0] r_b;
   logic [2:0]    r_drain;
   logic [2:0]    r_stage;

   logic [2:0]    w_s;
   logic [BW-1:0] w_b;
   logic [BW-1:0] w_mask;
   logic [BW-1:0] w_k;
   logic [BW-1:0] w_j;
   logic [AW-1:0] w_half;
   logic [AW-1:0] w_addr1;
   logic [AW-1:0] w_addr2;
   logic [BW-1:0] w_tw;

   // Stage/butterfly of the pair to be presented next cycle, and its addresses
   always_comb begin
      w_s = r_stage;
      w_b = r_b + BW'(1);
      if (r_state == IDLE) begin
         w_s = '0;
         w_b = '0;
      end else if (r_state == DRAIN) begin
         w_s = r_stage + 3'd1;
         w_b = '0;
      end
      w_half  = AW'(1) << w_s;
      w_mask  = (BW'(1) << w_s) - BW'(1);
      w_k     = w_b & w_mask;
      w_j     = w_b >> w_s;
      w_addr1 = ({1'b0, w_j} << ({1'b0, w_s} + 4'd1)) | {1'b0, w_k};
      w_addr2 = w_addr1 + w_half;
      w_tw    = w_k << (TW_SH - w_s);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_b        <= '0;
         r_drain    <= '0;
         r_stage    <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         rd_vld_o   <= 1'b0;
         rd_addr1_o <= '0;
         rd_addr2_o <= '0;
         tw_idx_o   <= '0;
      end else begin
         done_o     <= 1'b0;
         rd_vld_o   <= 1'b0;
         rd_addr1_o <= '0;
         rd_addr2_o <= '0;
         tw_idx_o   <= '0;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_state    <= RUN;
                  r_b        <= '0;
                  busy_o     <= 1'b1;
                  rd_vld_o   <= 1'b1;
                  rd_addr1_o <= w_addr1;
                  rd_addr2_o <= w_addr2;
                  tw_idx_o   <= w_tw;
               end
            end
            RUN: begin
               if (r_b == B_LAST) begin
                  r_state <= DRAIN;
                  r_drain <= '0;
               end else begin
                  r_b        <= w_b;
                  rd_vld_o   <= 1'b1;
                  rd_addr1_o <= w_addr1;
                  rd_addr2_o <= w_addr2;
                  tw_idx_o   <= w_tw;
               end
            end
            DRAIN: begin
               if (r_drain == D_LAST) begin
                  if (r_stage == S_LAST) begin
                     r_state <= DONE;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
                  end else begin
                     r_state    <= RUN;
                     r_stage    <= w_s;
                     r_b        <= '0;
                     rd_vld_o   <= 1'b1;
                     rd_addr1_o <= w_addr1;
                     rd_addr2_o <= w_addr2;
                     tw_idx_o   <= w_tw;
                  end
               end else begin
                  r_drain <= r_drain + 3'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_stage <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stage_o = r_stage;

   logic          r_wv  [BFY_LAT];
   logic [AW-1:0] r_wa1 [BFY_LAT];
   logic [AW-1:0] r_wa2 [BFY_LAT];

   // Write-back delay line; flushed by reset so no stale pair survives an abort
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BFY_LAT; i++) begin
            r_wv[i]  <= 1'b0;
            r_wa1[i] <= '0;
            r_wa2[i] <= '0;
         end
      end else begin
         r_wv[0]  <= rd_vld_o;
         r_wa1[0] <= rd_addr1_o;
         r_wa2[0] <= rd_addr2_o;
         for (int i = 1; i < BFY_LAT; i++) begin
            r_wv[i]  <= r_wv[i-1];
            r_wa1[i] <= r_wa1[i-1];
            r_wa2[i] <= r_wa2[i-1];
         end
      end
   end

   assign wr_vld_o   = r_wv[BFY_LAT-1];
   assign wr_addr1_o = r_wa1[BFY_LAT-1];
   assign wr_addr2_o = r_wa2[BFY_LAT-1];

endmodule
